// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: reduces a shift request to bounded passes through an
// external combinational shifter, feeding each pass result back as the next operand.
module shift_sequencer #(
  parameter int MAX_STEP = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] value,
  input  logic [7:0] amount,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [7:0] sh_data1,
  output logic [7:0] sh_data2,
  output logic [1:0] sh_rsc,
  output logic       sh_left,
  input  logic [7:0] sh_left_result,
  input  logic [7:0] sh_right_result,
  output logic [1:0] fsm_state
);

  localparam logic [2:0] MAX3 = 3'(MAX_STEP);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] op_q, op_nx;
  logic [7:0] acc, acc_nx;
  logic [7:0] remaining, rem_nx;
  logic [7:0] result_q, result_nx;
  logic [2:0] step;

  // Handshake: start is a one-cycle request accepted only when busy=0; the
  // answer is the done pulse with result valid in that same cycle. Requests
  // raised while busy are dropped, never queued.

  always_comb begin
    if (remaining > {5'b0, MAX3}) step = MAX3;
    else                          step = remaining[2:0];
  end

  always_comb begin
    state_nx  = state;
    op_nx     = op_q;
    acc_nx    = acc;
    rem_nx    = remaining;
    result_nx = result_q;
    case (state)
      IDLE: begin
        if (start) begin
          op_nx  = op;
          acc_nx = value;
          rem_nx = amount;
          if (op == OP_ROR) begin
            rem_nx = {5'b0, amount[2:0]};
          end else if (amount >= 8'd8) begin
            // Everything shifted out: answer is all-zero or all-sign without any pass.
            rem_nx = 8'd0;
            acc_nx = (op == OP_SRA) ? {8{value[7]}} : 8'h00;
          end
          state_nx = (rem_nx != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        acc_nx = sh_left ? sh_left_result : sh_right_result;
        rem_nx = remaining - {5'b0, step};
        if (remaining == {5'b0, step}) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Result is captured on entry to DONE so it is already valid during the pulse.
    if (state_nx == DONE && state != DONE) result_nx = acc_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      acc       <= 8'h00;
      remaining <= 8'h00;
      result_q  <= 8'h00;
    end else begin
      state     <= state_nx;
      op_q      <= op_nx;
      acc       <= acc_nx;
      remaining <= rem_nx;
      result_q  <= result_nx;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign result    = result_q;
  assign sh_data1  = acc;
  assign sh_data2  = (state == RUN) ? {5'b0, step} : 8'h00;
  assign sh_rsc    = op_q;
  assign sh_left   = (state == RUN) && (op_q == OP_SLL);
  assign fsm_state = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: two instances (MAX_STEP 7 and 2) each
// driven by a behavioural shifter model, checked against hand-computed results.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] value = 8'h00, amount = 8'h00;

  logic       busy_a, done_a, left_a, busy_b, done_b, left_b;
  logic [7:0] result_a, data1_a, data2_a, lres_a, rres_a;
  logic [7:0] result_b, data1_b, data2_b, lres_b, rres_b;
  logic [1:0] rsc_a, rsc_b, state_a, state_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int runs_a = 0, runs_b = 0, dones_b = 0, range_viol = 0;
  logic [7:0] step_log_b[$];
  logic [7:0] data_log_b[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] lshift(input logic [7:0] d, input logic [7:0] n);
    return d << n[2:0];
  endfunction

  function automatic logic [7:0] rshift(input logic [7:0] d, input logic [7:0] n, input logic [1:0] t);
    int k;
    k = int'(n[2:0]);
    case (t)
      2'b10:   return 8'($signed(d) >>> k);
      2'b11:   return (k == 0) ? d : 8'((d >> k) | (d << (8 - k)));
      default: return d >> k;
    endcase
  endfunction

  assign lres_a = lshift(data1_a, data2_a);
  assign rres_a = rshift(data1_a, data2_a, rsc_a);
  assign lres_b = lshift(data1_b, data2_b);
  assign rres_b = rshift(data1_b, data2_b, rsc_b);

  shift_sequencer #(.MAX_STEP(7)) dut_a (
    .CLK(clk), .RESET(rst), .start(start_a), .op(op), .value(value), .amount(amount),
    .busy(busy_a), .done(done_a), .result(result_a), .sh_data1(data1_a), .sh_data2(data2_a),
    .sh_rsc(rsc_a), .sh_left(left_a), .sh_left_result(lres_a), .sh_right_result(rres_a),
    .fsm_state(state_a)
  );

  shift_sequencer #(.MAX_STEP(2)) dut_b (
    .CLK(clk), .RESET(rst), .start(start_b), .op(op), .value(value), .amount(amount),
    .busy(busy_b), .done(done_b), .result(result_b), .sh_data1(data1_b), .sh_data2(data2_b),
    .sh_rsc(rsc_b), .sh_left(left_b), .sh_left_result(lres_b), .sh_right_result(rres_b),
    .fsm_state(state_b)
  );

  // RUN is the busy, non-done phase; pass amounts must stay within 1..MAX_STEP there.
  always @(negedge clk) begin
    if (busy_a && !done_a) begin
      runs_a++;
      if (data2_a == 8'd0 || data2_a > 8'd7) range_viol++;
    end
    if (busy_b && !done_b) begin
      runs_b++;
      step_log_b.push_back(data2_b);
      data_log_b.push_back(data1_b);
      if (data2_b == 8'd0 || data2_b > 8'd2) range_viol++;
    end
    if (done_b) dones_b++;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit on_b, input logic [1:0] o, input logic [7:0] v,
                        input logic [7:0] a, input logic [7:0] exp_res,
                        input int exp_lat, input int exp_runs, input string tag);
    int lat;
    int runs0;
    @(negedge clk);
    op = o; value = v; amount = a;
    exp_q.push_back(exp_res);
    step_log_b.delete();
    data_log_b.delete();
    runs0 = on_b ? runs_b : runs_a;
    if (on_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    lat = 1;
    while (!(on_b ? done_b : done_a) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
    check({tag, "_busy"}, 8'(on_b ? busy_b : busy_a), 8'd1);
    check({tag, "_res"}, on_b ? result_b : result_a, exp_q.pop_front());
    check({tag, "_runs"}, 8'((on_b ? runs_b : runs_a) - runs0), 8'(exp_runs));
    @(posedge clk); #1;
    check({tag, "_done_drop"}, 8'(on_b ? done_b : done_a), 8'd0);
    check({tag, "_idle"}, 8'(on_b ? busy_b : busy_a), 8'd0);
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 8'(busy_a), 8'd0);
    check("rst_done", 8'(done_a), 8'd0);
    check("rst_result", result_a, 8'h00);
    check("rst_data1", data1_a, 8'h00);
    check("rst_data2", data2_a, 8'h00);
    check("rst_rsc", 8'(rsc_a), 8'd0);
    check("rst_left", 8'(left_a), 8'd0);
    @(negedge clk) rst = 1'b0;

    // MAX_STEP = 7
    do_req(1'b0, 2'b00, 8'h01, 8'd3, 8'h08, 2, 1, "sll3");
    check("sll3_step", data2_a, 8'h00);
    do_req(1'b0, 2'b00, 8'hB5, 8'd5, 8'hA0, 2, 1, "sll5");
    do_req(1'b0, 2'b01, 8'hF0, 8'd10, 8'h00, 1, 0, "srl10");
    do_req(1'b0, 2'b01, 8'h80, 8'd7, 8'h01, 2, 1, "srl7");
    do_req(1'b0, 2'b10, 8'h80, 8'd9, 8'hFF, 1, 0, "sra9_neg");
    do_req(1'b0, 2'b10, 8'h40, 8'd9, 8'h00, 1, 0, "sra9_pos");
    do_req(1'b0, 2'b10, 8'h80, 8'd7, 8'hFF, 2, 1, "sra7");
    do_req(1'b0, 2'b11, 8'h81, 8'd9, 8'hC0, 2, 1, "ror9");
    do_req(1'b0, 2'b11, 8'h81, 8'd8, 8'h81, 1, 0, "ror8");
    do_req(1'b0, 2'b00, 8'h3C, 8'd0, 8'h3C, 1, 0, "zero_amt");

    // MAX_STEP = 2
    do_req(1'b1, 2'b10, 8'h80, 8'd5, 8'hFC, 4, 3, "sra5_ms2");
    check("sra5_step0", step_log_b.size() > 0 ? step_log_b[0] : 8'hEE, 8'd2);
    check("sra5_step2", step_log_b.size() > 2 ? step_log_b[2] : 8'hEE, 8'd1);
    check("sra5_acc1", data_log_b.size() > 1 ? data_log_b[1] : 8'hEE, 8'hE0);
    check("sra5_acc2", data_log_b.size() > 2 ? data_log_b[2] : 8'hEE, 8'hF8);
    do_req(1'b1, 2'b00, 8'h01, 8'd7, 8'h80, 5, 4, "sll7_ms2");
    do_req(1'b1, 2'b11, 8'h01, 8'd7, 8'h02, 5, 4, "ror7_ms2");

    // Reset in the second RUN cycle discards the request.
    @(negedge clk);
    op = 2'b10; value = 8'h80; amount = 8'd5; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    @(posedge clk); #1;
    check("mid_in_run", 8'(busy_b && !done_b), 8'd1);
    #2 rst = 1'b1;
    #1;
    d0 = dones_b;
    check("mid_rst_busy", 8'(busy_b), 8'd0);
    check("mid_rst_done", 8'(done_b), 8'd0);
    check("mid_rst_result", result_b, 8'h00);
    check("mid_rst_data2", data2_b, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_done", 8'(dones_b - d0), 8'd0);

    // Start while busy is ignored.
    @(negedge clk);
    op = 2'b10; value = 8'h80; amount = 8'd5; start_b = 1'b1;
    exp_q.push_back(8'hFC);
    @(posedge clk); #1 start_b = 1'b0;
    d0 = dones_b;
    @(negedge clk);
    op = 2'b00; value = 8'h11; amount = 8'd0; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    begin
      int lat;
      lat = 2;
      while (!done_b && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      check("busy_start_lat", 8'(lat), 8'd4);
      check("busy_start_res", result_b, exp_q.pop_front());
    end
    repeat (5) @(posedge clk);
    #1;
    check("busy_start_one_done", 8'(dones_b - d0), 8'd1);
    check("busy_start_idle", 8'(busy_b), 8'd0);
    check("busy_start_hold", result_b, 8'hFC);

    do_req(1'b1, 2'b00, 8'h5A, 8'd0, 8'h5A, 1, 0, "after_rst_zero");

    check("data2_range", 8'(range_viol), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
